// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding B/H/W/D access to a doubleword-wide memory.
// Sub-doubleword stores use read-modify-write; misaligned requests may trap.
module load_store_unit #(
    parameter int XLEN          = 64,
    parameter int IDX_SHIFT     = 3,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_misalign,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_read,
    output logic            mem_write,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP, ERR
    } state_t;

    state_t state, state_nxt;

    logic            unsigned_q;
    logic [1:0]      size_q;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q, merge_q;

    logic            hs, misal;
    logic [XLEN-1:0] addr_eff;
    logic [5:0]      bit_off;
    logic [XLEN-1:0] shifted, ext_data, size_mask, byte_mask, merged;

    assign req_ready = rst_n & (state == IDLE);
    assign hs        = req_valid & req_ready;

    always_comb begin
        misal    = 1'b0;
        addr_eff = req_addr;
        case (req_size)
            2'b01: begin
                misal       = req_addr[0];
                addr_eff[0] = 1'b0;
            end
            2'b10: begin
                misal         = |req_addr[1:0];
                addr_eff[1:0] = 2'b00;
            end
            2'b11: begin
                misal         = |req_addr[2:0];
                addr_eff[2:0] = 3'b000;
            end
            default: ;
        endcase
        // Without trapping, the request is forced onto its natural alignment.
        if (MISALIGN_TRAP) addr_eff = req_addr;
    end

    assign bit_off = {addr_q[2:0], 3'b000};
    assign shifted = mem_rdata >> bit_off;

    always_comb begin
        case (size_q)
            2'b00: begin
                ext_data = {{(XLEN-8){~unsigned_q & shifted[7]}},
                            shifted[7:0]};
                size_mask = {{(XLEN-8){1'b0}}, 8'hFF};
            end
            2'b01: begin
                ext_data = {{(XLEN-16){~unsigned_q & shifted[15]}},
                            shifted[15:0]};
                size_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
            end
            2'b10: begin
                ext_data = {{(XLEN-32){~unsigned_q & shifted[31]}},
                            shifted[31:0]};
                size_mask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
            end
            default: begin
                ext_data  = shifted;
                size_mask = '1;
            end
        endcase
    end

    assign byte_mask = size_mask << bit_off;
    assign merged    = (mem_rdata & ~byte_mask)
                     | ((wdata_q << bit_off) & byte_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unsigned_q <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            merge_q    <= '0;
        end else begin
            if (hs) begin
                unsigned_q <= req_unsigned;
                size_q     <= req_size;
                addr_q     <= addr_eff;
                wdata_q    <= req_wdata;
                rdata_q    <= '0;
            end
            if (state == LOAD)   rdata_q <= ext_data;
            if (state == RMW_RD) merge_q <= merged;
        end
    end

    assign resp_rdata = rdata_q;

    always_comb begin
        state_nxt     = state;
        resp_valid    = 1'b0;
        resp_misalign = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        case (state)
            IDLE: begin
                if (hs) begin
                    if (misal && MISALIGN_TRAP) state_nxt = ERR;
                    else if (!req_is_store)     state_nxt = LOAD;
                    else if (req_size == 2'b11) state_nxt = STORE;
                    else                        state_nxt = RMW_RD;
                end
            end
            LOAD: begin
                mem_read  = 1'b1;
                mem_addr  = addr_q >> IDX_SHIFT;
                state_nxt = RESP;
            end
            STORE: begin
                mem_write = 1'b1;
                mem_addr  = addr_q >> IDX_SHIFT;
                mem_wdata = wdata_q;
                state_nxt = RESP;
            end
            RMW_RD: begin
                mem_read  = 1'b1;
                mem_addr  = addr_q >> IDX_SHIFT;
                state_nxt = RMW_WR;
            end
            RMW_WR: begin
                mem_write = 1'b1;
                mem_addr  = addr_q >> IDX_SHIFT;
                mem_wdata = merge_q;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            ERR: begin
                resp_valid    = 1'b1;
                resp_misalign = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference memory,
// randomized requests, latency and memory-traffic checks per response.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_is_store, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_misalign;
    logic [63:0] resp_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misalign(resp_misalign),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mis;
        logic [63:0] rdata;
        int          cyc;
        int          rd;
        int          wr;
        logic [63:0] waddr;
        logic [63:0] wdata;
    } sb_t;

    sb_t         sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [63:0] last_rdata = '0;
    logic        mem_clear;

    logic [63:0] dmem [16];
    logic [7:0]  ref_mem [128];

    function automatic logic [63:0] init_word(input int i);
        return 64'h0123_4567_89AB_CDEF + 64'(i) * 64'h1111_1111_1111_1111;
    endfunction

    assign mem_rdata = dmem[mem_addr[3:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) dmem[i] <= init_word(i);
        end else if (mem_write) begin
            dmem[mem_addr[3:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_dword(input int idx);
        logic [63:0] v;
        for (int b = 0; b < 8; b++) v[8*b +: 8] = ref_mem[idx*8 + b];
        return v;
    endfunction

    function automatic bit is_misal(input logic [1:0] sz,
                                    input logic [63:0] a);
        int nb;
        nb = 1 << sz;
        return (a % nb) != 0;
    endfunction

    function automatic logic [63:0] ref_load(input logic [1:0] sz,
                                             input bit uns,
                                             input logic [63:0] a);
        logic [63:0] v;
        int nb;
        nb = 1 << sz;
        v = '0;
        for (int i = 0; i < nb; i++)
            v = v | (64'(ref_mem[int'(a) + i]) << (8*i));
        if (!uns && nb < 8 && v[8*nb-1])
            v = v | (~64'd0 << (8*nb));
        return v;
    endfunction

    // Monitor: count memory traffic per access, score each response.
    always @(negedge clk) begin
        sb_t e;
        if (!rst_n) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (mem_read) rd_cnt++;
            if (mem_write) begin
                wr_cnt++;
                if (sbq.size() > 0) begin
                    chk("mem_addr", mem_addr, sbq[0].waddr);
                    chk("mem_wdata", mem_wdata, sbq[0].wdata);
                end
            end
            if (resp_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_resp", 64'(resp_valid), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_misalign", 64'(resp_misalign), 64'(e.mis));
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("latency", 64'(cyc), 64'(e.cyc));
                    chk("mem_reads", 64'(rd_cnt), 64'(e.rd));
                    chk("mem_writes", 64'(wr_cnt), 64'(e.wr));
                    last_rdata = resp_rdata;
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    task automatic issue(input bit st, input logic [1:0] sz,
                         input bit uns, input logic [63:0] a,
                         input logic [63:0] wd, input bit abort);
        sb_t e;
        bit  m;
        int  n;
        int  nb;
        int  base;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 64'(req_ready), 64'd1);
            return;
        end
        req_valid    = 1'b1;
        req_is_store = st;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        m  = is_misal(sz, a);
        nb = 1 << sz;
        e.mis   = m;
        e.rdata = '0;
        e.waddr = a >> 3;
        e.wdata = '0;
        if (m)                    e.cyc = cyc + 1;
        else if (!st || sz == 3)  e.cyc = cyc + 2;
        else                      e.cyc = cyc + 3;
        e.rd = (!m && (!st || sz != 3)) ? 1 : 0;
        e.wr = (!m && st) ? 1 : 0;
        if (!m && !st) e.rdata = ref_load(sz, uns, a);
        if (!m && st && !abort) begin
            for (int i = 0; i < nb; i++)
                ref_mem[int'(a) + i] = wd[8*i +: 8];
            base  = int'(a) / 8;
            e.wdata = ref_dword(base);
        end
        if (!abort) sbq.push_back(e);
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_is_store = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = {$urandom, $urandom};
        req_wdata    = {$urandom, $urandom};
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] w;
        bit          st, uns;
        logic [1:0]  sz;
        logic [63:0] a, wd;
        int          quiet;

        rst_n        = 1'b0;
        mem_clear    = 1'b1;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        for (int i = 0; i < 16; i++) begin
            w = init_word(i);
            for (int b = 0; b < 8; b++) ref_mem[i*8 + b] = w[8*b +: 8];
        end

        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mem_read", 64'(mem_read), 64'd0);
        chk("rst_mem_write", 64'(mem_write), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        mem_clear = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(req_ready), 64'd1);

        issue(1, 2'b11, 0, 64'h10, 64'h1122_3344_5566_7788, 0);
        issue(0, 2'b11, 0, 64'h10, 64'h0, 0);
        drain();
        chk("load_d_value", last_rdata, 64'h1122_3344_5566_7788);
        issue(1, 2'b00, 0, 64'h13, 64'hAB, 0);
        issue(0, 2'b00, 0, 64'h13, 64'h0, 0);
        drain();
        chk("load_b_signed", last_rdata, 64'hFFFF_FFFF_FFFF_FFAB);
        issue(0, 2'b00, 1, 64'h13, 64'h0, 0);
        drain();
        chk("load_b_unsigned", last_rdata, 64'h0000_0000_0000_00AB);
        issue(0, 2'b10, 0, 64'h14, 64'h0, 0);
        drain();
        chk("load_w_value", last_rdata, 64'h0000_0000_1122_3344);
        issue(0, 2'b01, 0, 64'h11, 64'h0, 0);
        issue(1, 2'b11, 0, 64'h1C, 64'hDEAD, 0);
        drain();

        // Reset while the read half of a byte store is in flight.
        issue(1, 2'b00, 0, 64'h21, 64'h5A, 1);
        @(negedge clk);
        chk("abort_in_rmw_rd", 64'(mem_read), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_read", 64'(mem_read), 64'd0);
        chk("abort_mem_write", 64'(mem_write), 64'd0);
        chk("abort_req_ready", 64'(req_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid || mem_write) quiet++;
        end
        chk("abort_no_resp", 64'(quiet), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd1);
        issue(0, 2'b11, 0, 64'h20, 64'h0, 0);
        drain();

        for (int k = 0; k < 300; k++) begin
            st  = 1'($urandom);
            uns = 1'($urandom);
            sz  = 2'($urandom);
            a   = 64'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) a = (a >> sz) << sz;
            wd  = {$urandom, $urandom};
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(st, sz, uns, a, wd, 0);
        end
        drain();

        for (int i = 0; i < 16; i++)
            chk("final_mem", dmem[i], ref_dword(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
